pipe_arbiter: RTL and testbench
===============================

PIPE_ARBITER -- requirements
Module: pipe_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1, clock; all state updates on posedge CLK.
REQ-002 SHALL have port nRST, input, 1, reset: synchronous, active-low.
REQ-003 SHALL have port in0$enq__ENA, input, 1, requester 0 enqueue strobe; asserted only when in0$enq__RDY=1.
REQ-004 SHALL have port in0$enq$v, input, 96, requester 0 message; valid while in0$enq__ENA=1.
REQ-005 SHALL have port in0$enq__RDY, output, 1, requester 0 may enqueue this cycle.
REQ-006 SHALL have ports in1$enq__ENA, in1$enq$v, in1$enq__RDY, identical to REQ-003..005, for requester 1.
REQ-007 SHALL have port pipe$enq__ENA, output, 1, shared pipe enqueue strobe.
REQ-008 SHALL have port pipe$enq$v, output, 96, shared pipe message.
REQ-009 SHALL have port pipe$enq__RDY, input, 1, shared pipe can accept.
REQ-010 SHALL have ports count0 and count1, output, 16 each, messages forwarded per requester.

Function
REQ-011 SHALL hold one 96-bit entry per requester (hold_k) with a flag valid_k.
REQ-012 SHALL drive in_k$enq__RDY = !valid_k | (grant==k & pipe$enq__ENA), so the same-cycle drain-and-refill sustains 1 message/cycle per port.
REQ-013 SHALL capture in_k$enq$v into hold_k and set valid_k on in_k$enq__ENA; a simultaneous drain of port k SHALL NOT clear valid_k.
REQ-014 SHALL compute grant combinationally: both valid -> port != last; only one valid -> that port; none -> no grant.
REQ-015 SHALL drive pipe$enq__ENA = (valid0|valid1) & pipe$enq__RDY; never assert ENA while pipe$enq__RDY=0.
REQ-016 SHALL drive pipe$enq$v = hold_grant when any valid, else 96'h0.
REQ-017 SHALL, on pipe$enq__ENA: clear valid_grant unless refilled (REQ-013), set last <= grant, and increment count_grant.
REQ-018 SHALL hold last, all valid flags and hold contents while pipe$enq__RDY=0; the grant may change only through a newly valid port.
REQ-019 SHALL keep latency from in_k$enq__ENA to pipe$enq__ENA at a minimum of 1 cycle; there is no combinational bypass.
REQ-020 SHALL bound starvation: with both ports continuously valid and pipe ready, grants alternate 0,1,0,1...
REQ-021 SHALL wrap counters modulo 2^16 (16'hFFFF+1 -> 16'h0000).
REQ-022 SHALL never reorder messages from a single port or drop an accepted message.

Reset
REQ-023 SHALL, while nRST=0 at posedge CLK, clear valid0/valid1, set last=1 (port 0 wins first tie), and zero count0/count1; hold contents are don't-care.
REQ-024 SHALL keep outputs at reset values while nRST=0: pipe$enq__ENA=0, pipe$enq$v=0, in0/in1$enq__RDY=1.
REQ-025 SHALL discard any in-flight held message on reset assertion mid-operation, without emitting it.

Structure
REQ-026 SHALL place the 96-bit message width constant and the requester-count constant (2) in the shared package used by the pipe proxies.
REQ-027 SHALL implement each per-port holding stage as one sub-module, pipe_hold_slot (valid flag + 96-bit register + RDY logic), instantiated twice; arbitration and counters reside in pipe_arbiter.

Verification
REQ-028 SHALL cover single port: in0 sends 96'h1_00000005_0000002A with pipe ready -> pipe$enq__ENA one cycle later with that value, count0=1.
REQ-029 SHALL cover tie after reset: in0 and in1 enqueue in the same cycle -> port 0 first, port 1 next cycle, last=1, count0=count1=1.
REQ-030 SHALL cover backpressure: pipe$enq__RDY=0 for 5 cycles with both ports held -> no ENA, in0/in1 RDY=0, values unchanged; on release, both drain in order.
REQ-031 SHALL cover streaming: both ports send 8 messages back-to-back -> 16 pipe transfers, strictly alternating, per-port order preserved, no gaps.
REQ-032 SHALL cover wrap: preload count1=16'hFFFE, forward 3 messages -> count1 reads 16'hFFFF, 16'h0000, 16'h0001.
REQ-033 SHALL cover mid-operation reset: both valid, assert nRST for 1 cycle -> no pipe ENA, RDY=1, counters 0, held data never appears.

Source files
------------

// File: rtl/pipe_arbiter_pkg.sv
// pipe_arbiter_pkg -- shared constants and types for the pipe proxies.
//   MSG_W   : message width carried on every enq channel
//   NUM_REQ : number of requesters feeding the shared pipe
//   CNT_W   : width of the per-requester forwarded-message counters
package pipe_arbiter_pkg;
  localparam int MSG_W   = 96;
  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 16;

  typedef logic [MSG_W-1:0] msg_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/pipe_arbiter_if.sv
// pipe_arbiter_if -- one enq channel (strobe, message, ready).
//   enq__ENA : producer strobe, only while enq__RDY=1
//   enq_v    : message, valid while enq__ENA=1
//   enq__RDY : consumer can take a message this cycle
// master = producer side, slave = consumer side.
interface pipe_arbiter_if;
  import pipe_arbiter_pkg::*;
  logic enq__ENA;
  msg_t enq_v;
  logic enq__RDY;

  modport master(output enq__ENA, output enq_v, input enq__RDY);
  modport slave (input enq__ENA, input enq_v, output enq__RDY);
endinterface

// File: rtl/pipe_arbiter_hold_slot.sv
// pipe_hold_slot -- one-entry holding stage for a single requester.
//   CLK, nRST : clock, synchronous active-low reset
//   in_if     : requester enq channel (slave side)
//   drain     : this slot is being forwarded to the pipe this cycle
//   valid     : slot holds a message
//   hold      : held message
// RDY also covers the drain-and-refill case so one port can stream at
// 1 msg/cycle; during reset RDY reads 1 regardless of stale state.
module pipe_hold_slot
  import pipe_arbiter_pkg::*;
(
  input  logic                  CLK,
  input  logic                  nRST,
  pipe_arbiter_if.slave         in_if,
  input  logic                  drain,
  output logic                  valid,
  output msg_t                  hold
);

  // A refill in the same cycle as a drain wins, so valid stays set.
  always_ff @(posedge CLK) begin
    if (!nRST)                valid <= 1'b0;
    else if (in_if.enq__ENA)  valid <= 1'b1;
    else if (drain)           valid <= 1'b0;
  end

  // Contents are don't-care while invalid, so no reset on the data.
  always_ff @(posedge CLK) begin
    if (in_if.enq__ENA) hold <= in_if.enq_v;
  end

  assign in_if.enq__RDY = !nRST | !valid | drain;

endmodule

// File: rtl/pipe_arbiter.sv
// pipe_arbiter -- two requesters share one pipe enq channel.
//   CLK, nRST      : clock, synchronous active-low reset
//   in0, in1       : requester enq channels (slave side)
//   pipe           : shared pipe enq channel (master side)
//   count0, count1 : messages forwarded per requester, wrap mod 2^16
// Each requester lands in a one-entry slot (no combinational bypass);
// ties go to the port that did not win last, so a continuously busy pair
// alternates 0,1,0,1. last only moves on a transfer, so backpressure
// freezes the arbitration state.
module pipe_arbiter
  import pipe_arbiter_pkg::*;
(
  input  logic           CLK,
  input  logic           nRST,
  pipe_arbiter_if.slave  in0,
  pipe_arbiter_if.slave  in1,
  pipe_arbiter_if.master pipe,
  output cnt_t           count0,
  output cnt_t           count1
);

  logic [NUM_REQ-1:0]        valid;
  logic [NUM_REQ-1:0]        drain;
  msg_t                      hold [NUM_REQ];
  logic                      last;
  logic                      grant;
  logic                      any;
  logic                      ena;
  cnt_t [NUM_REQ-1:0]        cnt_q;

  pipe_hold_slot u_slot0 (
    .CLK   (CLK),
    .nRST  (nRST),
    .in_if (in0),
    .drain (drain[0]),
    .valid (valid[0]),
    .hold  (hold[0])
  );

  pipe_hold_slot u_slot1 (
    .CLK   (CLK),
    .nRST  (nRST),
    .in_if (in1),
    .drain (drain[1]),
    .valid (valid[1]),
    .hold  (hold[1])
  );

  // Both valid -> the port that did not win last; else the lone valid port.
  always_comb begin
    grant = valid[1];
    if (&valid) grant = ~last;
  end

  // Gate with nRST so outputs read their reset values during reset even
  // while the slots still hold pre-reset state.
  assign any      = nRST & (|valid);
  assign ena      = any & pipe.enq__RDY;
  assign drain[0] = ena & ~grant;
  assign drain[1] = ena &  grant;

  assign pipe.enq__ENA = ena;
  assign pipe.enq_v    = any ? hold[grant] : '0;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      last  <= 1'b1;
      cnt_q <= '0;
    end else if (ena) begin
      last         <= grant;
      cnt_q[grant] <= cnt_q[grant] + cnt_t'(1);
    end
  end

  assign count0 = cnt_q[0];
  assign count1 = cnt_q[1];

endmodule

// File: tb/tb_pipe_arbiter.sv
// tb_pipe_arbiter -- directed scenarios for pipe_arbiter with inline checks.
// Inputs change 1 time unit after posedge; outputs sampled on negedge.
module tb_pipe_arbiter;
  import pipe_arbiter_pkg::*;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  cnt_t count0, count1;
  int   checks = 0;
  int   passed = 0;

  pipe_arbiter_if in0_if ();
  pipe_arbiter_if in1_if ();
  pipe_arbiter_if pipe_if ();

  pipe_arbiter dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .in0    (in0_if),
    .in1    (in1_if),
    .pipe   (pipe_if),
    .count0 (count0),
    .count1 (count1)
  );

  always #5 CLK = ~CLK;

  function automatic msg_t mk(int k, int i);
    return {32'(k), 32'hC0DE_0000, 32'(i)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    tick();
    tick();
    @(negedge CLK);
    checks++;
    if (pipe_if.enq__ENA !== 1'b0) $display("FAIL reset_ena: got %b want 0", pipe_if.enq__ENA);
    else passed++;
    checks++;
    if (pipe_if.enq_v !== '0) $display("FAIL reset_v: got %h want 0", pipe_if.enq_v);
    else passed++;
    checks++;
    if ({in0_if.enq__RDY, in1_if.enq__RDY} !== 2'b11)
      $display("FAIL reset_rdy: got %b want 11", {in0_if.enq__RDY, in1_if.enq__RDY});
    else passed++;
    checks++;
    if ({count0, count1} !== 32'h0) $display("FAIL reset_cnt: got %h/%h want 0/0", count0, count1);
    else passed++;
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_single();
    msg_t a = 96'h1_00000005_0000002A;
    tick();
    in0_if.enq__ENA = 1'b1;
    in0_if.enq_v    = a;
    #1;
    checks++;
    if (pipe_if.enq__ENA !== 1'b0) $display("FAIL single_bypass: got ena %b want 0", pipe_if.enq__ENA);
    else passed++;
    tick();
    in0_if.enq__ENA = 1'b0;
    in0_if.enq_v    = '0;
    @(negedge CLK);
    checks++;
    if (pipe_if.enq__ENA !== 1'b1 || pipe_if.enq_v !== a)
      $display("FAIL single_fwd: got %b/%h want 1/%h", pipe_if.enq__ENA, pipe_if.enq_v, a);
    else passed++;
    tick();
    @(negedge CLK);
    checks++;
    if (pipe_if.enq__ENA !== 1'b0 || pipe_if.enq_v !== '0)
      $display("FAIL single_idle: got %b/%h want 0/0", pipe_if.enq__ENA, pipe_if.enq_v);
    else passed++;
    checks++;
    if (count0 !== 16'd1 || count1 !== 16'd0) $display("FAIL single_cnt: got %0d/%0d want 1/0", count0, count1);
    else passed++;
  endtask

  task automatic test_tie();
    tick();
    do_reset();
    in0_if.enq__ENA = 1'b1; in0_if.enq_v = mk(0, 100);
    in1_if.enq__ENA = 1'b1; in1_if.enq_v = mk(1, 100);
    tick();
    in0_if.enq__ENA = 1'b0;
    in1_if.enq__ENA = 1'b0;
    @(negedge CLK);
    checks++;
    if (pipe_if.enq__ENA !== 1'b1 || pipe_if.enq_v !== mk(0, 100))
      $display("FAIL tie_first: got %b/%h want 1/%h", pipe_if.enq__ENA, pipe_if.enq_v, mk(0, 100));
    else passed++;
    checks++;
    if ({in0_if.enq__RDY, in1_if.enq__RDY} !== 2'b10)
      $display("FAIL tie_rdy: got %b want 10", {in0_if.enq__RDY, in1_if.enq__RDY});
    else passed++;
    tick();
    @(negedge CLK);
    checks++;
    if (pipe_if.enq__ENA !== 1'b1 || pipe_if.enq_v !== mk(1, 100))
      $display("FAIL tie_second: got %b/%h want 1/%h", pipe_if.enq__ENA, pipe_if.enq_v, mk(1, 100));
    else passed++;
    tick();
    @(negedge CLK);
    checks++;
    if (pipe_if.enq__ENA !== 1'b0 || count0 !== 16'd1 || count1 !== 16'd1 || dut.last !== 1'b1)
      $display("FAIL tie_end: got ena %b cnt %0d/%0d last %b want 0 1/1 1",
               pipe_if.enq__ENA, count0, count1, dut.last);
    else passed++;
  endtask

  task automatic test_backpressure();
    tick();
    pipe_if.enq__RDY = 1'b0;
    in0_if.enq__ENA = 1'b1; in0_if.enq_v = mk(0, 200);
    in1_if.enq__ENA = 1'b1; in1_if.enq_v = mk(1, 200);
    tick();
    in0_if.enq__ENA = 1'b0;
    in1_if.enq__ENA = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if ({pipe_if.enq__ENA, in0_if.enq__RDY, in1_if.enq__RDY} !== 3'b000 || pipe_if.enq_v !== mk(0, 200))
        $display("FAIL bp_hold%0d: got ena/rdy %b v %h want 000 %h", i,
                 {pipe_if.enq__ENA, in0_if.enq__RDY, in1_if.enq__RDY}, pipe_if.enq_v, mk(0, 200));
      else passed++;
      tick();
    end
    pipe_if.enq__RDY = 1'b1;
    @(negedge CLK);
    checks++;
    if (pipe_if.enq__ENA !== 1'b1 || pipe_if.enq_v !== mk(0, 200))
      $display("FAIL bp_drain0: got %b/%h want 1/%h", pipe_if.enq__ENA, pipe_if.enq_v, mk(0, 200));
    else passed++;
    tick();
    @(negedge CLK);
    checks++;
    if (pipe_if.enq__ENA !== 1'b1 || pipe_if.enq_v !== mk(1, 200))
      $display("FAIL bp_drain1: got %b/%h want 1/%h", pipe_if.enq__ENA, pipe_if.enq_v, mk(1, 200));
    else passed++;
    tick();
    @(negedge CLK);
    checks++;
    if (pipe_if.enq__ENA !== 1'b0 || count0 !== 16'd2 || count1 !== 16'd2)
      $display("FAIL bp_end: got ena %b cnt %0d/%0d want 0 2/2", pipe_if.enq__ENA, count0, count1);
    else passed++;
  endtask

  task automatic test_stream();
    msg_t got [$];
    int   gotc [$];
    tick();
    fork
      begin
        int n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
          in0_if.enq__ENA = in0_if.enq__RDY;
          in0_if.enq_v    = mk(0, n);
          if (in0_if.enq__RDY) n++;
          tick();
        end
        in0_if.enq__ENA = 1'b0;
      end
      begin
        int n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
          in1_if.enq__ENA = in1_if.enq__RDY;
          in1_if.enq_v    = mk(1, n);
          if (in1_if.enq__RDY) n++;
          tick();
        end
        in1_if.enq__ENA = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge CLK);
          if (pipe_if.enq__ENA === 1'b1) begin
            got.push_back(pipe_if.enq_v);
            gotc.push_back(c);
          end
        end
      end
    join
    checks++;
    if (got.size() != 16) $display("FAIL stream_count: got %0d transfers want 16", got.size());
    else passed++;
    for (int j = 0; j < 16 && j < got.size(); j++) begin
      checks++;
      if (got[j] !== mk(j % 2, j / 2))
        $display("FAIL stream_order%0d: got %h want %h", j, got[j], mk(j % 2, j / 2));
      else passed++;
    end
    if (gotc.size() == 16) begin
      checks++;
      if (gotc[15] - gotc[0] != 15) $display("FAIL stream_gaps: got span %0d want 15", gotc[15] - gotc[0]);
      else passed++;
    end
    checks++;
    if (count0 !== 16'd10 || count1 !== 16'd10) $display("FAIL stream_cnt: got %0d/%0d want 10/10", count0, count1);
    else passed++;
  endtask

  task automatic test_wrap();
    cnt_t exp [3] = '{16'hFFFF, 16'h0000, 16'h0001};
    int   bad = 0;
    tick();
    do_reset();
    // Bring count1 to 16'hFFFE by streaming port 1 alone.
    in1_if.enq__ENA = 1'b1;
    for (int j = 0; j < 65534; j++) begin
      if (in1_if.enq__RDY !== 1'b1) bad++;
      in1_if.enq_v = mk(1, j);
      tick();
    end
    in1_if.enq__ENA = 1'b0;
    tick();
    @(negedge CLK);
    checks++;
    if (bad != 0) $display("FAIL wrap_rdy: got %0d not-ready cycles want 0", bad);
    else passed++;
    checks++;
    if (count1 !== 16'hFFFE || count0 !== 16'h0) $display("FAIL wrap_pre: got %h/%h want 0000/fffe", count0, count1);
    else passed++;
    tick();
    for (int i = 0; i < 3; i++) begin
      in1_if.enq__ENA = 1'b1;
      in1_if.enq_v    = mk(1, 70000 + i);
      tick();
      in1_if.enq__ENA = 1'b0;
      tick();
      @(negedge CLK);
      checks++;
      if (count1 !== exp[i]) $display("FAIL wrap%0d: got %h want %h", i, count1, exp[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_midreset();
    pipe_if.enq__RDY = 1'b0;
    in0_if.enq__ENA = 1'b1; in0_if.enq_v = mk(0, 300);
    in1_if.enq__ENA = 1'b1; in1_if.enq_v = mk(1, 300);
    tick();
    in0_if.enq__ENA = 1'b0;
    in1_if.enq__ENA = 1'b0;
    nRST = 1'b0;
    @(negedge CLK);
    checks++;
    if (pipe_if.enq__ENA !== 1'b0 || pipe_if.enq_v !== '0 || {in0_if.enq__RDY, in1_if.enq__RDY} !== 2'b11)
      $display("FAIL mrst_during: got ena %b v %h rdy %b want 0 0 11",
               pipe_if.enq__ENA, pipe_if.enq_v, {in0_if.enq__RDY, in1_if.enq__RDY});
    else passed++;
    tick();
    nRST = 1'b1;
    pipe_if.enq__RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (pipe_if.enq__ENA !== 1'b0 || pipe_if.enq_v !== '0)
        $display("FAIL mrst_after%0d: got %b/%h want 0/0", i, pipe_if.enq__ENA, pipe_if.enq_v);
      else passed++;
      tick();
    end
    checks++;
    if (count0 !== 16'd0 || count1 !== 16'd0) $display("FAIL mrst_cnt: got %0d/%0d want 0/0", count0, count1);
    else passed++;
  endtask

  initial begin
    in0_if.enq__ENA  = 1'b0;
    in0_if.enq_v     = '0;
    in1_if.enq__ENA  = 1'b0;
    in1_if.enq_v     = '0;
    pipe_if.enq__RDY = 1'b1;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_stream();
    test_wrap();
    test_midreset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
